newton_join_buffer: RTL and testbench

Parametrised fork/join alignment buffer for the Newton-iteration datapath. A stage result consumed both immediately and several stages later, such as the x-correction term feeding the final subtractor, enters branch A and is held in a DEPTH-entry FIFO. When the long-path result arrives on branch B, the oldest A word and the B word are released together as one registered operand pair. All three ports use valid/ready handshakes, so the buffer absorbs any skew between the branches up to DEPTH words.

---
 rtl/newton_join_buffer.sv | 116 +++++++++++
 tb/tb_newton_join_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/newton_join_buffer.sv
// newton_join_buffer: fork/join alignment buffer for the Newton datapath.
// Branch A words wait in a DEPTH-entry FIFO until a branch B word arrives.
// The oldest A word and the B word then leave together as one registered pair.
// Optional feature macro: NEWTON_JOIN_BYPASS_EN. When it is defined, an empty
// FIFO lets a_data pair directly with b_data in one edge.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   a_data/a_vd/a_rd   short-path operand in
//   b_data/b_vd/b_rd   long-path operand in
//   out_a/out_b        registered operand pair
//   out_vd/out_rd      pair handshake
//   count              FIFO occupancy, 0..DEPTH
module newton_join_buffer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_vd,
    output logic             a_rd,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_vd,
    output logic             b_rd,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_vd,
    input  logic             out_rd,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HELD  = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;

    logic free;
    logic nempty;
    logic byp;
    logic join_f;
    logic push;
    logic load;

    assign out_vd = (state == HELD);
    assign count  = cnt;
    assign free   = !out_vd || out_rd;
    assign nempty = (cnt != '0);

    // a_rd looks only at the registered count, gated low while in reset.
    assign a_rd = rst_n && (cnt < FULL);

`ifdef NEWTON_JOIN_BYPASS_EN
    assign byp  = rst_n && !nempty && a_vd && b_vd && free;
    assign b_rd = rst_n && (nempty || a_vd) && free;
`else
    assign byp  = 1'b0;
    assign b_rd = rst_n && nempty && free;
`endif

    assign join_f = rst_n && b_vd && nempty && free;
    // A bypassed word goes straight to out_a and never occupies the FIFO.
    assign push   = a_vd && a_rd && !byp;
    assign load   = join_f || byp;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (join_f) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, join_f})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // The output pair register. It reloads back-to-back when a join
    // coincides with the downstream taking the current pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            out_a <= '0;
            out_b <= '0;
        end else if (load) begin
            state <= HELD;
            out_a <= byp ? a_data : mem[rd_ptr];
            out_b <= b_data;
        end else if (out_rd) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_newton_join_buffer.sv
// tb_newton_join_buffer: scoreboard bench for newton_join_buffer.
// A queue-level model predicts ready/count/pairs, and a monitor checks the pairs.
module tb_newton_join_buffer;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);
`ifdef NEWTON_JOIN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a_data;
    logic          a_vd;
    logic          a_rd;
    logic [W-1:0]  b_data;
    logic          b_vd;
    logic          b_rd;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          out_vd;
    logic          out_rd;
    logic [CW-1:0] count;

    newton_join_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_data (a_data),
        .a_vd   (a_vd),
        .a_rd   (a_rd),
        .b_data (b_data),
        .b_vd   (b_vd),
        .b_rd   (b_rd),
        .out_a  (out_a),
        .out_b  (out_b),
        .out_vd (out_vd),
        .out_rd (out_rd),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    logic [W-1:0]   aq [$];
    logic [2*W-1:0] sb [$];
    bit             held = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, output as a held flag.
    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                chk("rst_a_rd", int'(a_rd), 0);
                chk("rst_b_rd", int'(b_rd), 0);
                chk("rst_count", int'(count), 0);
                chk("rst_out_vd", int'(out_vd), 0);
                chk("rst_out_a", int'(out_a), 0);
                chk("rst_out_b", int'(out_b), 0);
                aq.delete();
                sb.delete();
                held = 1'b0;
            end else begin
                bit free;
                bit e_ard;
                bit e_brd;
                bit took;
                free  = !held || out_rd;
                e_ard = aq.size() < D;
                e_brd = (aq.size() != 0 || (BYP && a_vd)) && free;
                chk("a_rd", int'(a_rd), int'(e_ard));
                chk("b_rd", int'(b_rd), int'(e_brd));
                chk("count", int'(count), aq.size());
                chk("out_vd", int'(out_vd), int'(held));
                took = 1'b0;
                if (BYP && aq.size() == 0 && a_vd && b_vd && free) begin
                    sb.push_back({a_data, b_data});
                    took = 1'b1;
                end else begin
                    if (b_vd && aq.size() != 0 && free) begin
                        sb.push_back({aq.pop_front(), b_data});
                        took = 1'b1;
                    end
                    if (a_vd && e_ard) aq.push_back(a_data);
                end
                if (took) held = 1'b1;
                else if (out_rd) held = 1'b0;
            end
        end
    end

    // Monitor: checks each delivered pair and output stability under stall.
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    bit           stall_prev = 1'b0;
    always @(negedge clk) begin
        if (!done) begin
            if (rst_n && stall_prev) begin
                chk("hold_a", int'(out_a), int'(pa));
                chk("hold_b", int'(out_b), int'(pb));
            end
            stall_prev = rst_n && out_vd && !out_rd;
            pa = out_a;
            pb = out_b;
            if (rst_n && out_vd && out_rd) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected got %0d,%0d expected none",
                             out_a, out_b);
                end else begin
                    logic [2*W-1:0] e;
                    e = sb.pop_front();
                    chk("pair_a", int'(out_a), int'(e[2*W-1:W]));
                    chk("pair_b", int'(out_b), int'(e[W-1:0]));
                end
            end
        end
    end

    task automatic step(input bit r, input bit av, input int a,
                        input bit bv, input int b, input bit ord);
        @(posedge clk);
        #1;
        rst_n  = r;
        a_vd   = av;
        a_data = W'(a);
        b_vd   = bv;
        b_data = W'(b);
        out_rd = ord;
    endtask

    initial begin
        rst_n  = 1'b0;
        a_vd   = 1'b0;
        a_data = '0;
        b_vd   = 1'b0;
        b_data = '0;
        out_rd = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Three A words, then three B words back to back.
        step(1, 1, 1, 0, 0, 1);
        step(1, 1, 2, 0, 0, 1);
        step(1, 1, 3, 0, 0, 1);
        step(1, 0, 0, 1, 3, 1);
        step(1, 0, 0, 1, 2, 1);
        step(1, 0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);

        // Fill past DEPTH with the output blocked, then stall and drain.
        for (int i = 0; i < 10; i++) step(1, 1, $urandom, 0, 0, 0);
        step(1, 1, $urandom, 1, $urandom, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, $urandom, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, $urandom, 1);
        step(1, 0, 0, 0, 0, 1);

        // Random skew on both branches and on the downstream ready.
        for (int i = 0; i < 300; i++) begin
            step(1, ($urandom % 3) != 0, $urandom,
                 ($urandom % 3) != 0, $urandom, ($urandom % 4) != 0);
        end
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1, $urandom, 1);

        // Reset with four words queued and a pair held.
        for (int i = 0; i < 5; i++) step(1, 1, 10 + i, 0, 0, 0);
        step(1, 0, 0, 1, 99, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 7, 1, 7, 1);
        step(1, 1, 40, 0, 0, 1);
        step(1, 1, 41, 0, 0, 1);
        step(1, 0, 0, 1, 50, 1);
        step(1, 0, 0, 1, 51, 1);

        // Push and pull in the same cycle on an empty FIFO.
        step(1, 1, 2, 1, 1, 1);
        step(1, 0, 0, 1, 5, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);

        @(posedge clk);
        done = 1'b1;
        chk("sb_drained", sb.size(), 0);
        chk("fifo_drained", aq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
